// File: rtl/gray_counter_codec_if.sv
// Bundles the counter controls/outputs and the Gray decoder channel of gray_counter_codec.
// The master side drives the strobes and the slave side is the codec itself.
interface gray_counter_codec_if #(
    parameter int N = 4
);
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] load_bin;
    logic [N-1:0] gray_q;
    logic [N-1:0] bin_q;
    logic         wrap;
    logic         dec_valid_in;
    logic [N-1:0] dec_gray_in;
    logic         dec_valid_out;
    logic [N-1:0] dec_bin_out;
    logic         dec_err;

    modport master (
        output en, up, load, load_bin, dec_valid_in, dec_gray_in,
        input  gray_q, bin_q, wrap, dec_valid_out, dec_bin_out, dec_err
    );

    modport slave (
        input  en, up, load, load_bin, dec_valid_in, dec_gray_in,
        output gray_q, bin_q, wrap, dec_valid_out, dec_bin_out, dec_err
    );
endinterface

// File: rtl/gray_counter_codec.sv
// Up/down binary counter with registered Gray output, plus an independent
// Gray-to-binary decoder that flags non-adjacent successive samples.
module gray_counter_codec #(
    parameter int N   = 4,
    parameter bit SAT = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    gray_counter_codec_if.slave bus
);
    localparam logic [N-1:0] ZERO = {N{1'b0}};
    localparam logic [N-1:0] MAX  = {N{1'b1}};
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    function automatic logic [N-1:0] bin_to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A nonzero difference with more than one bit set is an adjacency violation.
    function automatic logic multi_bit_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] d;
        d = a ^ b;
        return (d & (d - ONE)) != ZERO;
    endfunction

    logic [N-1:0] bin_r;
    logic [N-1:0] gray_r;
    logic         wrap_r;
    logic [N-1:0] bin_nxt_s;
    logic         wrap_nxt_s;

    logic         dec_valid_r;
    logic [N-1:0] dec_bin_r;
    logic         dec_err_r;
    logic [N-1:0] prev_r;
    logic         have_prev_r;

    // Counter next state: load beats enable, enable beats hold.
    always_comb begin
        bin_nxt_s  = bin_r;
        wrap_nxt_s = 1'b0;
        if (bus.load) begin
            bin_nxt_s = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up) begin
                if (bin_r == MAX) begin
                    if (SAT) begin
                        bin_nxt_s = bin_r;
                    end else begin
                        bin_nxt_s  = ZERO;
                        wrap_nxt_s = 1'b1;
                    end
                end else begin
                    bin_nxt_s = bin_r + ONE;
                end
            end else begin
                if (bin_r == ZERO) begin
                    if (SAT) begin
                        bin_nxt_s = bin_r;
                    end else begin
                        bin_nxt_s  = MAX;
                        wrap_nxt_s = 1'b1;
                    end
                end else begin
                    bin_nxt_s = bin_r - ONE;
                end
            end
        end else begin
            bin_nxt_s = bin_r;
        end
    end

    // Counter registers; Gray is encoded from the next state so both outputs are flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= ZERO;
            gray_r <= ZERO;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= bin_nxt_s;
            gray_r <= bin_to_gray(bin_nxt_s);
            wrap_r <= wrap_nxt_s;
        end
    end

    // Decoder pipeline stage with previous-word tracking for adjacency checks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_r <= 1'b0;
            dec_bin_r   <= ZERO;
            dec_err_r   <= 1'b0;
            prev_r      <= ZERO;
            have_prev_r <= 1'b0;
        end else begin
            dec_valid_r <= bus.dec_valid_in;
            if (bus.dec_valid_in) begin
                dec_bin_r   <= gray_to_bin(bus.dec_gray_in);
                dec_err_r   <= have_prev_r & multi_bit_diff(prev_r, bus.dec_gray_in);
                prev_r      <= bus.dec_gray_in;
                have_prev_r <= 1'b1;
            end else begin
                dec_bin_r   <= dec_bin_r;
                dec_err_r   <= dec_err_r;
                prev_r      <= prev_r;
                have_prev_r <= have_prev_r;
            end
        end
    end

    assign bus.bin_q         = bin_r;
    assign bus.gray_q        = gray_r;
    assign bus.wrap          = wrap_r;
    assign bus.dec_valid_out = dec_valid_r;
    assign bus.dec_bin_out   = dec_bin_r;
    assign bus.dec_err       = dec_err_r;
endmodule

// File: tb/tb_gray_counter_codec.sv
// Scoreboard bench: drivers push expected results, a monitor compares after each edge.
module tb_gray_counter_codec;
    logic clk;
    logic rst_n;

    gray_counter_codec_if #(.N(4)) bus0 ();
    gray_counter_codec_if #(.N(4)) bus1 ();

    gray_counter_codec #(.N(4), .SAT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gray_counter_codec #(.N(4), .SAT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
    } cnt_exp_t;

    typedef struct packed {
        logic [3:0] bin;
        logic       err;
    } dec_exp_t;

    cnt_exp_t q0[$];
    cnt_exp_t q1[$];
    dec_exp_t dq[$];

    // Hand-written 4-bit Gray sequence.
    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step0(input logic ld, input logic e, input logic u, input logic [3:0] lb,
                         input logic [3:0] eb, input logic ew);
        cnt_exp_t x;
        @(negedge clk);
        bus0.load = ld; bus0.en = e; bus0.up = u; bus0.load_bin = lb;
        x.bin = eb; x.gray = gtab[eb]; x.wrap = ew;
        q0.push_back(x);
    endtask

    task automatic step1(input logic ld, input logic e, input logic u, input logic [3:0] lb,
                         input logic [3:0] eb, input logic ew);
        cnt_exp_t x;
        @(negedge clk);
        bus1.load = ld; bus1.en = e; bus1.up = u; bus1.load_bin = lb;
        x.bin = eb; x.gray = gtab[eb]; x.wrap = ew;
        q1.push_back(x);
    endtask

    task automatic dstep(input logic v, input logic [3:0] g, input logic [3:0] eb, input logic ee);
        dec_exp_t x;
        @(negedge clk);
        bus0.dec_valid_in = v; bus0.dec_gray_in = g;
        if (v) begin
            x.bin = eb; x.err = ee;
            dq.push_back(x);
        end
    endtask

    // Monitor: one step after each rising edge, compare whatever is due.
    always begin
        cnt_exp_t c;
        dec_exp_t d;
        @(posedge clk);
        #1;
        chk("gray_rel0", {28'h0, bus0.gray_q}, {28'h0, bus0.bin_q ^ (bus0.bin_q >> 1)});
        chk("gray_rel1", {28'h0, bus1.gray_q}, {28'h0, bus1.bin_q ^ (bus1.bin_q >> 1)});
        if (q0.size() > 0) begin
            c = q0.pop_front();
            chk("cnt0_bin",  {28'h0, bus0.bin_q},  {28'h0, c.bin});
            chk("cnt0_gray", {28'h0, bus0.gray_q}, {28'h0, c.gray});
            chk("cnt0_wrap", {31'h0, bus0.wrap},   {31'h0, c.wrap});
        end
        if (q1.size() > 0) begin
            c = q1.pop_front();
            chk("cnt1_bin",  {28'h0, bus1.bin_q},  {28'h0, c.bin});
            chk("cnt1_gray", {28'h0, bus1.gray_q}, {28'h0, c.gray});
            chk("cnt1_wrap", {31'h0, bus1.wrap},   {31'h0, c.wrap});
        end
        if (bus0.dec_valid_out) begin
            if (dq.size() == 0) begin
                chk("dec_stray_valid", 32'h1, 32'h0);
            end else begin
                d = dq.pop_front();
                chk("dec_bin", {28'h0, bus0.dec_bin_out}, {28'h0, d.bin});
                chk("dec_err", {31'h0, bus0.dec_err},     {31'h0, d.err});
            end
        end else if (dq.size() > 0) begin
            chk("dec_latency", 32'h0, 32'h1);
            d = dq.pop_front();
        end
    end

    initial begin
        rst_n = 1'b0;
        bus0.en = 1'b0; bus0.up = 1'b0; bus0.load = 1'b0; bus0.load_bin = 4'h0;
        bus0.dec_valid_in = 1'b0; bus0.dec_gray_in = 4'h0;
        bus1.en = 1'b0; bus1.up = 1'b0; bus1.load = 1'b0; bus1.load_bin = 4'h0;
        bus1.dec_valid_in = 1'b0; bus1.dec_gray_in = 4'h0;
        #2;
        chk("rst_bin",  {28'h0, bus0.bin_q},       32'h0);
        chk("rst_gray", {28'h0, bus0.gray_q},      32'h0);
        chk("rst_wrap", {31'h0, bus0.wrap},        32'h0);
        chk("rst_dv",   {31'h0, bus0.dec_valid_out}, 32'h0);
        chk("rst_db",   {28'h0, bus0.dec_bin_out}, 32'h0);
        chk("rst_de",   {31'h0, bus0.dec_err},     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter and decoder run side by side.
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    step0(1'b0, 1'b1, 1'b1, 4'h0, 4'(i + 1), (i == 15));
                end
                step0(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
                step0(1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1);
                step0(1'b0, 1'b1, 1'b0, 4'h0, 4'hE, 1'b0);
                step0(1'b1, 1'b1, 1'b1, 4'h9, 4'h9, 1'b0);
                step0(1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 1'b0);
                step0(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
                step0(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
                step0(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            end
            begin
                dstep(1'b1, 4'h8, 4'hF, 1'b0);
                dstep(1'b1, 4'h9, 4'hE, 1'b0);
                dstep(1'b1, 4'hF, 4'hA, 1'b1);
                dstep(1'b1, 4'hF, 4'hA, 1'b0);
                dstep(1'b0, 4'h3, 4'h0, 1'b0);
                dstep(1'b1, 4'hE, 4'hB, 1'b0);
                dstep(1'b0, 4'h0, 4'h0, 1'b0);
            end
        join

        // Saturating instance: down into 0, then up against 15.
        step1(1'b1, 1'b0, 1'b0, 4'h2, 4'h2, 1'b0);
        step1(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0);
        step1(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        step1(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        step1(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        step1(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0);
        step1(1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 1'b0);
        step1(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);

        // Short asynchronous reset between edges while the counter sits at 7.
        step0(1'b1, 1'b0, 1'b0, 4'h7, 4'h7, 1'b0);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bin",  {28'h0, bus0.bin_q},         32'h0);
        chk("arst_gray", {28'h0, bus0.gray_q},        32'h0);
        chk("arst_dv",   {31'h0, bus0.dec_valid_out}, 32'h0);
        chk("arst_db",   {28'h0, bus0.dec_bin_out},   32'h0);
        chk("arst_de",   {31'h0, bus0.dec_err},       32'h0);
        chk("arst_bin1", {28'h0, bus1.bin_q},         32'h0);
        #1;
        rst_n = 1'b1;

        fork
            begin
                step0(1'b0, 1'b1, 1'b1, 4'h0, 4'h1, 1'b0);
                step0(1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0);
            end
            begin
                dstep(1'b1, 4'h3, 4'h2, 1'b0);
                dstep(1'b1, 4'h0, 4'h0, 1'b1);
                dstep(1'b0, 4'h0, 4'h0, 1'b0);
            end
        join

        repeat (3) @(negedge clk);
        chk("drain_q0", q0.size(), 32'h0);
        chk("drain_q1", q1.size(), 32'h0);
        chk("drain_dq", dq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gray_counter_codec.md
GRAY_COUNTER_CODEC -- requirements
Module: gray_counter_codec

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N, 4, code width in bits; legal range 2..32.
- SAT, 0, 0 = wrap at end of range, 1 = saturate at end of range.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, count enable.
- up, in, 1, direction: 1 = increment, 0 = decrement.
- load, in, 1, synchronous load strobe.
- load_bin, in, N, binary value to load.
- gray_q, out, N, counter value in Gray code (registered).
- bin_q, out, N, the same counter value in binary (registered).
- wrap, out, 1, one-cycle pulse on wrap-around.
- dec_valid_in, in, 1, decoder sample strobe.
- dec_gray_in, in, N, Gray word to decode.
- dec_valid_out, out, 1, decoder result valid.
- dec_bin_out, out, N, decoded binary value.
- dec_err, out, 1, Gray adjacency violation flag.
REQ-003 One clock, clk; reset rst_n is asynchronous and active-low.

Function: counter
REQ-004 The counter state shall be held in binary; gray_q shall equal bin_q ^ (bin_q >> 1), and both outputs shall come directly from flops, with no combinational path from any input.
REQ-005 Per-cycle priority: load, then en, then hold.
REQ-006 When load=1, bin_q shall take load_bin on the next edge, regardless of en and up, and wrap shall be 0.
REQ-007 When en=1 and up=1 with bin_q < 2^N-1, bin_q shall increment by 1.
REQ-008 When en=1 and up=0 with bin_q > 0, bin_q shall decrement by 1.
REQ-009 At the end of range (up=1 at 2^N-1, or up=0 at 0) with SAT=0, bin_q shall wrap to 0 or 2^N-1 respectively, and wrap shall be 1 for exactly that cycle.
REQ-010 At the end of range with SAT=1, bin_q shall hold its value and wrap shall stay 0.
REQ-011 Successive gray_q values shall differ in exactly one bit on every count step, including wrap; a load has no adjacency guarantee.
REQ-012 When en=0 and load=0, all counter outputs shall hold and wrap shall be 0.

Function: decoder channel
REQ-013 dec_bin_out[N-1] shall equal dec_gray_in[N-1], and each lower bit i shall equal dec_bin_out[i+1] ^ dec_gray_in[i]; the result is registered with a latency of exactly 1 cycle.
REQ-014 dec_valid_out shall equal dec_valid_in delayed by 1 cycle; dec_bin_out and dec_err shall hold while dec_valid_out=0.
REQ-015 The decoder shall keep the last accepted Gray word plus a have_prev flag, which is cleared by reset and set on the first accepted sample.
REQ-016 dec_err shall be 1, together with dec_valid_out, when have_prev=1 and the new word differs from the previous word in 2 or more bits.
REQ-017 Identical words (0 bits different) shall not be an error; the first sample after reset shall never be an error.
REQ-018 The counter and the decoder shall be independent; simultaneous activity on both shall not interact.

Reset
REQ-019 On rst_n=0, independent of clk, the block shall immediately clear bin_q, gray_q, wrap, dec_valid_out, dec_bin_out, dec_err, have_prev and the stored previous word to 0.
REQ-020 Reset asserted mid-count shall abort the operation; the first edge after rst_n deasserts shall act on the inputs as normal, starting from 0.
REQ-021 A reset pulse shorter than one clock period shall still clear all state.

Verification (N=4)
REQ-022 Up-count: reset, then en=1, up=1 for 16 cycles -> bin_q runs 0..15 then 0; gray_q runs 0000,0001,0011,0010,0110,...,1000 then 0000; wrap=1 only on the 15->0 cycle.
REQ-023 Down-count with SAT=1: load_bin=2, then en=1, up=0 for 4 cycles -> bin_q runs 2,1,0,0,0; wrap stays 0.
REQ-024 Load priority: en=1, up=1, load=1, load_bin=9 -> next cycle bin_q=9, gray_q=1101, wrap=0.
REQ-025 Decoder: send 1000, then 1001, then 1111 on consecutive cycles -> one cycle later dec_bin_out is 1111, 1110, 1010 with dec_err 0, 0, 1.
REQ-026 Async reset: assert rst_n=0 between edges while bin_q=7 -> outputs read 0 before the next edge; the first sample sent to the decoder after reset gives dec_err=0.
REQ-027 Throughout every scenario, a checker shall confirm gray_q equals bin_q ^ (bin_q >> 1) on every cycle.
